// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter that lends one SPI slave to N_REQ requesters, shifting DATA_W
// bits LSB first per transaction and returning the captured word tagged with the owner id.
module spi_xfer_arbiter #(
    parameter int N_REQ      = 2,
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      rsp_valid,
    output logic [$clog2(N_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      busy,
    output logic                      cs,
    output logic                      mosi,
    input  logic                      miso
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [CNT_W-1:0]   r_cnt;
    logic [GAP_W-1:0]   r_gap;
    logic [DATA_W-1:0]  r_tx;
    logic [DATA_W-1:0]  r_rx;

    logic               w_found;
    logic [ID_W-1:0]    w_gnt_id;
    logic [N_REQ-1:0]   w_onehot;
    logic [DATA_W-1:0]  w_wdata;
    int                 w_idx;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_onehot = '0;
        w_wdata  = '0;
        w_idx    = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = (int'(r_ptr) + i) % N_REQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found         = 1'b1;
                w_gnt_id        = w_idx[ID_W-1:0];
                w_onehot[w_idx] = 1'b1;
                w_wdata         = req_wdata[w_idx*DATA_W +: DATA_W];
            end
        end
    end

    assign req_ready = (r_state == S_IDLE) ? w_onehot : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            cs        <= 1'b1;
            mosi      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
            r_ptr     <= ID_W'(N_REQ - 1);
            r_id      <= '0;
            r_cnt     <= '0;
            r_gap     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_tx    <= w_wdata;
                        mosi    <= w_wdata[0];
                        r_id    <= w_gnt_id;
                        r_ptr   <= w_gnt_id;
                        r_cnt   <= '0;
                        cs      <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_rx  <= {miso, r_rx[DATA_W-1:1]};
                    r_tx  <= r_tx >> 1;
                    mosi  <= r_tx[1];
                    r_cnt <= r_cnt + 1'b1;
                    // Last sample goes straight into the response so it is visible in the first GAP cycle.
                    if (r_cnt == CNT_LAST) begin
                        cs        <= 1'b1;
                        mosi      <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_id    <= r_id;
                        rsp_rdata <= {miso, r_rx[DATA_W-1:1]};
                        r_gap     <= '0;
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Bench for spi_xfer_arbiter: a shift-out slave model (reset value 8'hAD, zero fill),
// an expected-transaction queue consumed by a negedge monitor, and a GAP_CYCLES=3 instance.
module tb_spi_xfer_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_wdata;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_id;
    logic [7:0]  rsp_rdata;
    logic        busy, cs, mosi, miso;

    logic [1:0]  vb;
    logic [15:0] wb;
    logic [1:0]  rdyb;
    logic        rvb, idb;
    logic [7:0]  rdb;
    logic        busyb, csb, mosib, misob;

    spi_xfer_arbiter #(.N_REQ(2), .DATA_W(8), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_rdata(rsp_rdata), .busy(busy), .cs(cs), .mosi(mosi), .miso(miso));

    spi_xfer_arbiter #(.N_REQ(2), .DATA_W(8), .GAP_CYCLES(3)) dut_gap3 (
        .clk(clk), .rst(rst), .req_valid(vb), .req_wdata(wb),
        .req_ready(rdyb), .rsp_valid(rvb), .rsp_id(idb),
        .rsp_rdata(rdb), .busy(busyb), .cs(csb), .mosi(mosib), .miso(misob));

    // Slave models: shift right while selected, zero fill, bit 0 on miso.
    logic [7:0] s_reg, s_reg_b, slv_val;
    logic       slv_load;
    always @(posedge clk) begin
        if (!rst)          s_reg <= 8'hAD;
        else if (slv_load) s_reg <= slv_val;
        else if (!cs)      s_reg <= {1'b0, s_reg[7:1]};
    end
    always @(posedge clk) begin
        if (!rst)      s_reg_b <= 8'hAD;
        else if (!csb) s_reg_b <= {1'b0, s_reg_b[7:1]};
    end
    assign miso  = s_reg[0];
    assign misob = s_reg_b[0];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: event not seen as required", name);
    endtask

    typedef struct { int id; logic [7:0] wdata; logic [7:0] rdata; } exp_t;
    typedef struct { int id; logic [7:0] wdata; logic [7:0] preload; logic [7:0] exp_rdata; } vec_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   in_flight = 0;
    int   run = 0;
    int   hs_cyc = 0;
    int   n_rsp = 0;
    int   ready_cycles = 0;
    int   gnt_cyc_q[$];
    logic [7:0] mosi_cap = '0;

    // Monitor for the GAP_CYCLES=1 instance.
    always @(negedge clk) begin
        if (!rst) begin
            in_flight = 0;
            run = 0;
        end else begin
            if (req_ready != 2'b00) begin
                ready_cycles++;
                chk("ready_onehot", $countones(req_ready), 1);
                chk("ready_only_valid", req_ready & ~req_valid, 0);
            end
            if (busy) chk("ready_zero_busy", req_ready, 0);
            if (|(req_valid & req_ready)) begin
                if (exp_q.size() == 0) fail_now("grant_expected");
                else begin
                    cur = exp_q.pop_front();
                    chk("grant_id", req_ready[1] ? 1 : 0, cur.id);
                    in_flight = 1;
                    hs_cyc = cyc;
                    gnt_cyc_q.push_back(cyc);
                end
            end
            if (!cs) begin
                run++;
                mosi_cap = {mosi, mosi_cap[7:1]};
            end else if (run > 0) begin
                chk("cs_low_len", run, 8);
                chk("mosi_bits", mosi_cap, cur.wdata);
                run = 0;
            end
            if (rsp_valid) begin
                if (!in_flight) fail_now("rsp_expected");
                else begin
                    chk("rsp_id", rsp_id, cur.id);
                    chk("rsp_rdata", rsp_rdata, cur.rdata);
                    chk("rsp_latency", cyc - hs_cyc, 9);
                end
                in_flight = 0;
                n_rsp++;
            end
        end
    end

    task automatic do_req(input int id, input logic [7:0] wd);
        bit got = 0;
        @(posedge clk); #1;
        req_wdata[id*8 +: 8] = wd;
        req_valid[id] = 1'b1;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1;
        end
        @(posedge clk); #1 req_valid[id] = 1'b0;
        if (!got) fail_now("grant_timeout");
    endtask

    task automatic wait_rsp(input int target);
        for (int k = 0; k < 40 && n_rsp < target; k++) @(negedge clk);
        if (n_rsp < target) fail_now("rsp_timeout");
        for (int k = 0; k < 10 && busy; k++) @(negedge clk);
    endtask

    task automatic load_slave(input logic [7:0] v);
        @(posedge clk); #1 slv_load = 1'b1; slv_val = v;
        @(posedge clk); #1 slv_load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[4];
    int   base, bad, nb_gnt, nb_rsp, hi_run, rdy_bad;
    bit   seen_low, drop;

    initial begin
        vecs[0] = '{1, 8'hA5, 8'h5A, 8'h5A};
        vecs[1] = '{0, 8'hFF, 8'h01, 8'h01};
        vecs[2] = '{0, 8'h81, 8'h80, 8'h80};
        vecs[3] = '{1, 8'h6E, 8'hC3, 8'hC3};
        rst = 1'b0; req_valid = '0; req_wdata = '0; vb = '0; wb = '0;
        slv_load = 1'b0; slv_val = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_cs", cs, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);

        // Single transaction from the slave reset value, then zero-filled slave.
        ready_cycles = 0;
        exp_q.push_back('{0, 8'h3C, 8'hAD});
        do_req(0, 8'h3C);
        @(negedge clk);
        chk("shift_busy", busy, 1);
        chk("shift_cs", cs, 0);
        wait_rsp(1);
        chk("ready_one_cycle", ready_cycles, 1);
        exp_q.push_back('{0, 8'hC5, 8'h00});
        do_req(0, 8'hC5);
        wait_rsp(2);

        for (int i = 0; i < 4; i++) begin
            load_slave(vecs[i].preload);
            exp_q.push_back('{vecs[i].id, vecs[i].wdata, vecs[i].exp_rdata});
            base = n_rsp;
            do_req(vecs[i].id, vecs[i].wdata);
            wait_rsp(base + 1);
        end

        // Reset clears the response registers left by the last transaction.
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst2_rsp_rdata", rsp_rdata, 0);
        chk("rst2_rsp_id", rsp_id, 0);

        // Both requesters held valid: round-robin order and grant spacing.
        gnt_cyc_q.delete();
        exp_q.push_back('{0, 8'h12, 8'hAD});
        exp_q.push_back('{1, 8'h34, 8'h00});
        exp_q.push_back('{0, 8'h12, 8'h00});
        exp_q.push_back('{1, 8'h34, 8'h00});
        base = n_rsp;
        @(posedge clk); #1 req_wdata = {8'h34, 8'h12}; req_valid = 2'b11;
        for (int k = 0; k < 60 && gnt_cyc_q.size() < 4; k++) @(negedge clk);
        @(posedge clk); #1 req_valid = 2'b00;
        wait_rsp(base + 4);
        if (gnt_cyc_q.size() == 4) begin
            for (int i = 1; i < 4; i++) chk("rr_spacing", gnt_cyc_q[i] - gnt_cyc_q[i-1], 10);
        end else fail_now("rr_four_grants");

        // Reset in the fourth SHIFT cycle abandons the transaction.
        exp_q.push_back('{0, 8'h55, 8'h00});
        do_req(0, 8'h55);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_cs", cs, 1);
        chk("abort_busy", busy, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        chk("abort_no_rsp", bad, 0);
        base = n_rsp;
        exp_q.push_back('{0, 8'h0F, 8'hAD});
        do_req(0, 8'h0F);
        wait_rsp(base + 1);

        // GAP_CYCLES=3 instance, back-to-back.
        nb_gnt = 0; nb_rsp = 0; hi_run = 0; rdy_bad = 0; seen_low = 0; drop = 0;
        @(posedge clk); #1 wb = {8'h34, 8'h12}; vb = 2'b11;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (busyb && rdyb != 2'b00) rdy_bad++;
            if (|(vb & rdyb)) begin
                if (nb_gnt < 3) chk("b_grant_id", rdyb[1] ? 1 : 0, nb_gnt % 2);
                nb_gnt++;
                if (nb_gnt == 3) drop = 1;
            end
            if (rvb) begin
                if (nb_rsp < 3) begin
                    chk("b_rsp_id", idb, nb_rsp % 2);
                    chk("b_rsp_rdata", rdb, (nb_rsp == 0) ? 8'hAD : 8'h00);
                end
                nb_rsp++;
            end
            if (csb) hi_run++;
            else begin
                if (seen_low && hi_run > 0) chk("b_cs_high_gap", hi_run, 4);
                seen_low = 1;
                hi_run = 0;
            end
            if (drop) begin
                @(posedge clk); #1 vb = 2'b00;
                drop = 0;
            end
        end
        chk("b_grants", nb_gnt, 3);
        chk("b_rsps", nb_rsp, 3);
        chk("b_ready_in_gap", rdy_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
